// File: rtl/shift_pkg.sv
// Shared definitions for the 64-bit shared arithmetic right shifter:
// widths, output-buffer state encoding and the round-robin pick helper.
package shift_pkg;

    localparam int unsigned INT64_WIDTH       = 64;
    localparam int unsigned INT64_SHIFT_WIDTH = 6;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // One-hot grant of the first set valid bit, scanning ptr, ptr+1, ... mod n.
    // Sized for up to 8 requesters; callers zero-extend their inputs.
    function automatic logic [7:0] rr_pick(
        input logic [7:0]  valid,
        input logic [2:0]  ptr,
        input int unsigned n
    );
        logic [7:0] grant;
        logic       found;
        logic [2:0] idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k < n) begin
                idx = 3'((32'(ptr) + k) % n);
                if (!found && valid[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter: one-hot grant starting the search at ptr, plus the
// binary index of the granted requester. enable=0 suppresses every grant.
module rr_arbiter_onehot
    import shift_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    always_comb begin
        grant = enable ? NREQ'(rr_pick(8'(valid), 3'(ptr), NREQ)) : '0;
        grant_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/shift_r_nbit_arith.sv
// Combinational N-bit arithmetic right shifter built as a log-depth barrel
// shifter; vacated positions are filled with the operand's sign bit.
module shift_r_nbit_arith #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned SHIFT_WIDTH = 6
) (
    input  logic [WIDTH-1:0]       a,
    input  logic [SHIFT_WIDTH-1:0] b,
    output logic [WIDTH-1:0]       y
);

    logic [WIDTH-1:0] stage;

    always_comb begin
        stage = a;
        for (int unsigned s = 0; s < SHIFT_WIDTH; s++) begin
            if (b[s]) begin
                stage = WIDTH'($signed(stage) >>> (1 << s));
            end
        end
        y = stage;
    end

endmodule

// File: rtl/shift_r_arb_int64.sv
// Shares one 64-bit arithmetic right shifter between NREQ valid/ready
// requesters via a round-robin arbiter and a single-entry tagged result buffer.
module shift_r_arb_int64
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH       = INT64_WIDTH,
    parameter int unsigned SHIFT_WIDTH = INT64_SHIFT_WIDTH,
    parameter int unsigned NREQ        = 4,
    parameter int unsigned IDW         = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_y,
    output logic [IDW-1:0]        out_id
);

    state_t                 state;
    logic [IDW-1:0]         rr_ptr;
    logic                   can_accept;
    logic [NREQ-1:0]        grant;
    logic [IDW-1:0]         grant_idx;
    logic                   fire;
    logic [WIDTH-1:0]       a_sel;
    logic [SHIFT_WIDTH-1:0] b_sel;
    logic [WIDTH-1:0]       y_shift;

    // Draining and refilling the buffer can happen in the same cycle.
    assign can_accept = (state == ST_EMPTY) | out_ready;
    assign req_ready  = grant;
    assign fire       = |grant;
    assign out_valid  = (state == ST_FULL);

    rr_arbiter_onehot #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .enable    (can_accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        a_sel = req_a[grant_idx*WIDTH +: WIDTH];
        b_sel = req_b[grant_idx*WIDTH +: SHIFT_WIDTH];
    end

    shift_r_nbit_arith #(
        .WIDTH       (WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_shift (
        .a (a_sel),
        .b (b_sel),
        .y (y_shift)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_EMPTY;
            out_y  <= '0;
            out_id <= '0;
            rr_ptr <= '0;
        end else begin
            if (fire) begin
                state  <= ST_FULL;
                out_y  <= y_shift;
                out_id <= grant_idx;
                rr_ptr <= (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
            end else if (out_ready) begin
                // Result consumed with nothing to replace it; data holds.
                state <= ST_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_shift_r_arb_int64.sv
// Self-checking bench for shift_r_arb_int64: directed scenarios then random
// traffic, compared against a behavioural round-robin/shift reference model.
module tb_shift_r_arb_int64;

    localparam int N = 4;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*64-1:0] req_a    = '0;
    logic [N*64-1:0] req_b    = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [63:0]    out_y;
    logic [1:0]     out_id;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_valid = 1'b0;
    logic [63:0] m_y     = '0;
    int          m_id    = 0;
    int          m_ptr   = 0;

    shift_r_arb_int64 #(.NREQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    // Arithmetic shift as floor division: negative values shift their complement.
    function automatic logic [63:0] ref_sra(input logic [63:0] a, input logic [63:0] b);
        int unsigned s;
        s = int'(b % 64);
        if (a[63]) return ~((~a) >> s);
        return a >> s;
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [63:0] a, input logic [63:0] b);
        req_valid[i]       = v;
        req_a[i*64 +: 64]  = a;
        req_b[i*64 +: 64]  = b;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_y     = '0;
        m_id    = 0;
        m_ptr   = 0;
    endtask

    // One clock: check ready before the edge, outputs just after it.
    task automatic do_cycle(input string tag);
        int          g;
        logic        can;
        logic [N-1:0] er;
        logic [63:0] ny;
        #1;
        can = !m_valid || out_ready;
        g   = pick(req_valid, m_ptr);
        er  = '0;
        ny  = '0;
        if (can && g >= 0) er[g] = 1'b1;
        chk({tag, " req_ready"}, 64'(req_ready), 64'(er));
        if (g >= 0) ny = ref_sra(req_a[g*64 +: 64], req_b[g*64 +: 64]);
        @(posedge clk);
        if (can) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_y     = ny;
                m_id    = g;
                m_ptr   = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk({tag, " out_valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, " out_y"}, out_y, m_y);
        chk({tag, " out_id"}, 64'(out_id), 64'(m_id));
    endtask

    initial begin
        // Reset
        @(posedge clk);
        #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_y", out_y, 64'd0);
        chk("reset out_id", 64'(out_id), 64'd0);
        #2 rst_n = 1'b1;
        model_reset();

        // Single request on req 0
        out_ready = 1'b1;
        set_req(0, 1'b1, 64'h8000_0000_0000_0000, 64'd4);
        do_cycle("single");
        chk("single y const", out_y, 64'hF800_0000_0000_0000);
        chk("single id const", 64'(out_id), 64'd0);
        set_req(0, 1'b0, '0, '0);

        // Shift amount masking and boundaries on req 2
        set_req(2, 1'b1, 64'h0000_0000_0000_1000, 64'hFFFF_FFFF_FFFF_FFC7);
        do_cycle("mask7");
        chk("mask7 y const", out_y, 64'h20);
        chk("mask7 id const", 64'(out_id), 64'd2);
        set_req(2, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'd0);
        do_cycle("shift0");
        chk("shift0 y const", out_y, 64'h1234_5678_9ABC_DEF0);
        set_req(2, 1'b1, 64'h8000_0000_0000_0000, 64'd63);
        do_cycle("shift63");
        chk("shift63 y const", out_y, 64'hFFFF_FFFF_FFFF_FFFF);
        set_req(2, 1'b0, '0, '0);
        do_cycle("drain");
        chk("drain valid const", 64'(out_valid), 64'd0);

        // Round-robin with all requesters valid
        for (int i = 0; i < N; i++) set_req(i, 1'b1, {$urandom, $urandom}, 64'($urandom_range(0, 63)));
        for (int c = 0; c < 8; c++) do_cycle("rr");

        // Backpressure with req 1 and req 3 valid
        set_req(0, 1'b0, '0, '0);
        set_req(2, 1'b0, '0, '0);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) do_cycle("bp hold");
        out_ready = 1'b1;
        do_cycle("bp release");

        // Async reset while FULL, released between edges
        chk("pre-reset full", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async out_valid", 64'(out_valid), 64'd0);
        chk("async out_y", out_y, 64'd0);
        chk("async out_id", 64'(out_id), 64'd0);
        model_reset();
        #2 rst_n = 1'b1;
        req_valid = '0;
        set_req(1, 1'b1, 64'hFFFF_0000_0000_0000, 64'd8);
        set_req(2, 1'b1, 64'h0F00, 64'd4);
        do_cycle("post-reset");
        chk("post-reset id const", 64'(out_id), 64'd1);
        req_valid = '0;
        do_cycle("post-reset drain");

        // Fairness skip from a freshly reset pointer
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
        set_req(3, 1'b1, 64'hC000_0000_0000_0001, 64'd1);
        do_cycle("skip3");
        chk("skip3 id const", 64'(out_id), 64'd3);
        set_req(0, 1'b1, 64'h100, 64'd2);
        do_cycle("skip wrap");
        chk("skip wrap id const", 64'(out_id), 64'd0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) begin
                req_a[i*64 +: 64] = {$urandom, $urandom};
                req_b[i*64 +: 64] = {$urandom, $urandom};
            end
            do_cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_r_arb_int64.md
Name: shift_r_arb_int64

Overview:
- Shares one 64-bit arithmetic right shifter (shift_r_nbit_arith, WIDTH=64, SHIFT_WIDTH=6) between NREQ requesters.
- Each requester uses a valid/ready request channel.
- A round-robin arbiter picks one request per cycle and feeds it to the shifter. The result is registered into a single-entry output buffer tagged with the requester ID.
- Sits between PIM compute lanes and the shared shift unit.

Parameters:
- WIDTH, 64, operand/result width; fixed at 64 for this block.
- SHIFT_WIDTH, 6, number of low bits of the shift operand used as shift amount.
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of requester ID tag.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept strobe.
- req_a  input  NREQ*WIDTH  flattened operands; slice i = [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  flattened shift operands; only bits [SHIFT_WIDTH-1:0] of each slice are used.
- out_valid  output  1  result buffer holds a valid result.
- out_ready  input  1  consumer accepts result.
- out_y  output  WIDTH  A >>> B[5:0], sign-extended.
- out_id  output  IDW  index of requester that produced out_y.

Behaviour:
- Clock, reset and state:
  - One clock, clk; reset is asynchronous and active-low, rst_n.
  - On reset assertion, immediately: out_valid=0, out_y=0, out_id=0, rr_ptr=0, FSM=EMPTY. Any in-flight result is discarded.
  - FSM has two states. EMPTY means the buffer is free. FULL means the buffer holds a result (out_valid = (state==FULL)).
- Acceptance and grant:
  - can_accept = (state==EMPTY) | out_ready. This is combinational, so the buffer drains and refills in the same cycle.
  - Grant search: first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - grant is one-hot or zero. req_ready[i] = can_accept & grant[i]. At most one ready bit is high per cycle.
  - req_ready depends combinationally on req_valid and out_ready; there is no other combinational path input-to-output.
- Handshakes:
  - Request handshake: req_valid[i] & req_ready[i] at a clock edge. The selected A/B go through the shifter, and the result is captured into out_y and out_id=i at that edge.
  - Latency is 1 cycle from request handshake to out_valid.
- Transitions:
  - EMPTY + grant -> FULL.
  - EMPTY + no valid requests -> EMPTY.
  - FULL + out_ready + grant -> FULL, buffer reloaded with the new result.
  - FULL + out_ready + no grant -> EMPTY; out_y/out_id hold their last value.
  - FULL + !out_ready -> FULL; out_y/out_id stay stable and all req_ready=0.
- Round-robin pointer:
  - After a grant to requester k, rr_ptr <= (k+1) mod NREQ.
  - Without a grant, rr_ptr is unchanged.
  - This guarantees no starvation: any valid requester is served within NREQ handshakes.
- Throughput is 1 result/cycle when out_ready is held high.
- Arithmetic:
  - out_y = signed A arithmetic-right-shifted by B[5:0], range 0..63.
  - B[63:6] is ignored. Shift 0 passes A unchanged; shift 63 gives all sign bits.
- Requester protocol:
  - Requesters must hold req_a/req_b stable while req_valid is high and not accepted. The block does not check this.
  - A requester deasserting valid before acceptance is allowed; it simply is not granted.

Decomposition:
- Shared package shift_pkg holds:
  - localparams INT64_WIDTH=64 and INT64_SHIFT_WIDTH=6;
  - the FSM state enum (ST_EMPTY, ST_FULL);
  - a function rr_pick(valid, ptr) returning a one-hot grant.
- Sub-modules: reuse the existing shift_r_nbit_arith unchanged as the datapath.
- One new sub-module, rr_arbiter_onehot (NREQ param; inputs valid/ptr/enable; outputs grant and grant index), is natural and reusable. The FSM, pointer update and output buffer live in the top.

Test Plan:
- Reset then single request, req 0: A=0x8000_0000_0000_0000, B=4 -> after 1 cycle out_valid=1, out_y=0xF800_0000_0000_0000, out_id=0.
- Width masking, req 2: A=0x0000_0000_0000_1000, B=0xFFFF_FFFF_FFFF_FFC7 (amount 7) -> out_y=0x20, out_id=2. Also B=0 -> out_y=A, and A=0x8000_0000_0000_0000 with B=63 -> out_y=0xFFFF_FFFF_FFFF_FFFF.
- Round-robin: all 4 req_valid high continuously, out_ready=1 -> out_id sequence 0,1,2,3,0,...; exactly one req_ready per cycle; 1 result/cycle.
- Backpressure: buffer FULL with out_ready=0 for 5 cycles while req 1 and req 3 are valid -> out_y/out_id stable and req_ready=0. Then out_ready=1 for one cycle -> pending result drained and next grant loaded in the same cycle.
- Fairness skip: only req 3 valid with rr_ptr=0 -> grant 3, rr_ptr becomes 0. Then req 0 and req 3 both valid -> grant 0 first.
- Async reset mid-operation: assert rst_n=0 between clock edges while FULL -> out_valid, out_y, out_id, rr_ptr go to 0 immediately. After release, the first grant goes to the lowest-indexed valid requester.
